// File: rtl/l2_rr_arbiter.sv
// l2_rr_arbiter: round-robin arbiter of NUM_CH L1 miss ports onto a single L2 port
//   clk, rst                    clock, synchronous active-high reset
//   ch_address_i, ch_wdata_i    per-channel address / write burst, channel i at slice i
//   ch_read_i, ch_write_i       per-channel request, held until ch_resp_o
//   ch_resp_o                   one-cycle completion pulse to the granted channel
//   ch_rdata_o                  unregistered broadcast of l2_rdata_i
//   l2_address_o, l2_wdata_o    address / burst to L2, latched at grant
//   l2_read_o, l2_write_o       registered strobes to L2
//   l2_resp_i, l2_rdata_i       single-cycle L2 completion and read burst
//   ch_svc_count_o              saturating completed-transaction count per channel
module l2_rr_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 16,
    parameter int BURST_W = 128,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH*ADDR_W-1:0]  ch_address_i,
    input  logic [NUM_CH-1:0]         ch_read_i,
    input  logic [NUM_CH-1:0]         ch_write_i,
    input  logic [NUM_CH*BURST_W-1:0] ch_wdata_i,
    output logic [NUM_CH-1:0]         ch_resp_o,
    output logic [BURST_W-1:0]        ch_rdata_o,
    output logic [ADDR_W-1:0]         l2_address_o,
    output logic                      l2_read_o,
    output logic                      l2_write_o,
    output logic [BURST_W-1:0]        l2_wdata_o,
    input  logic                      l2_resp_i,
    input  logic [BURST_W-1:0]        l2_rdata_i,
    output logic [NUM_CH*CNT_W-1:0]   ch_svc_count_o
);
    localparam int IW = $clog2(NUM_CH);
    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
    state_t             state_q, state_d;
    logic [IW-1:0]      last_q, last_d, gnt_q, gnt_d, pick;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BURST_W-1:0] wdata_q, wdata_d;
    logic               rd_q, rd_d, wr_q, wr_d, found;
    logic [NUM_CH-1:0]  req;
    logic [CNT_W-1:0]   cnt_q [NUM_CH];
    logic [CNT_W-1:0]   cnt_d [NUM_CH];
    int                 idx;
    // Search starts just after the last served channel, wrapping modulo NUM_CH.
    always_comb begin
        req = ch_read_i | ch_write_i;
        pick = '0;
        found = 1'b0;
        idx = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = int'(last_q) + k;
            idx = (idx >= NUM_CH) ? idx - NUM_CH : idx;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick = IW'(idx);
            end
        end
    end
    always_comb begin
        state_d = state_q;
        last_d = last_q;
        gnt_d = gnt_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        rd_d = rd_q;
        wr_d = wr_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: if (found) begin
                gnt_d = pick;
                addr_d = ch_address_i[int'(pick)*ADDR_W +: ADDR_W];
                wdata_d = ch_wdata_i[int'(pick)*BURST_W +: BURST_W];
                wr_d = ch_write_i[pick];
                rd_d = ~ch_write_i[pick];
                state_d = BUSY;
            end
            BUSY: if (l2_resp_i) begin
                rd_d = 1'b0;
                wr_d = 1'b0;
                last_d = gnt_q;
                cnt_d[gnt_q] = cnt_q[gnt_q] + CNT_W'(~&cnt_q[gnt_q]);
                state_d = RELEASE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q <= IW'(NUM_CH - 1);
            gnt_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            cnt_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            last_q <= last_d;
            gnt_q <= gnt_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            rd_q <= rd_d;
            wr_q <= wr_d;
            cnt_q <= cnt_d;
        end
    end
    always_comb begin
        ch_resp_o = '0;
        if (!rst && state_q == BUSY && l2_resp_i) ch_resp_o[gnt_q] = 1'b1;
    end
    assign ch_rdata_o = l2_rdata_i;
    assign l2_address_o = addr_q;
    assign l2_wdata_o = wdata_q;
    assign l2_read_o = rd_q;
    assign l2_write_o = wr_q;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
        assign ch_svc_count_o[i*CNT_W +: CNT_W] = cnt_q[i];
    end
endmodule

// File: tb/tb_l2_rr_arbiter.sv
// tb_l2_rr_arbiter: directed scoreboard bench for a 4-channel l2_rr_arbiter
module tb_l2_rr_arbiter;
    localparam int N = 4;
    logic           clk = 1'b0;
    logic           rst;
    logic [N*16-1:0]  ch_address;
    logic [N-1:0]     ch_read, ch_write, ch_resp;
    logic [N*128-1:0] ch_wdata;
    logic [127:0]     ch_rdata, l2_wdata, l2_rdata;
    logic [15:0]      l2_address;
    logic             l2_read, l2_write, l2_resp;
    logic [N*16-1:0]  ch_svc_count;
    int n_checks = 0;
    int n_fail = 0;
    typedef struct {
        int           ch;
        logic [127:0] rdata;
        logic [15:0]  addr;
        logic         wr;
        logic [127:0] wdata;
    } exp_t;
    exp_t sbq[$];

    l2_rr_arbiter #(.NUM_CH(N), .ADDR_W(16), .BURST_W(128), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .ch_address_i(ch_address), .ch_read_i(ch_read), .ch_write_i(ch_write),
        .ch_wdata_i(ch_wdata), .ch_resp_o(ch_resp), .ch_rdata_o(ch_rdata),
        .l2_address_o(l2_address), .l2_read_o(l2_read), .l2_write_o(l2_write),
        .l2_wdata_o(l2_wdata), .l2_resp_i(l2_resp), .l2_rdata_i(l2_rdata),
        .ch_svc_count_o(ch_svc_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int ch, input logic [127:0] rd, input logic [15:0] a,
                        input logic w, input logic [127:0] wd);
        exp_t e;
        e.ch = ch; e.rdata = rd; e.addr = a; e.wr = w; e.wdata = wd;
        sbq.push_back(e);
    endtask

    // Scoreboard monitor: samples 2 ns before each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (ch_resp !== '0) begin
                if (sbq.size() == 0) check("spurious_resp", 128'(ch_resp), 128'd0);
                else begin
                    e = sbq.pop_front();
                    check("resp_onehot", 128'(ch_resp), 128'(4'b1 << e.ch));
                    check("resp_rdata", ch_rdata, e.rdata);
                    check("resp_addr", 128'(l2_address), 128'(e.addr));
                    check("resp_write", 128'(l2_write), 128'(e.wr));
                    check("resp_read", 128'(l2_read), 128'(!e.wr));
                    if (e.wr) check("resp_wdata", l2_wdata, e.wdata);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ch_read = '0; ch_write = '0; l2_resp = 1'b0; l2_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_strobe(input int exp_lat);
        int t = 0;
        while (!(l2_read | l2_write) && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("strobe_latency", 128'(t), 128'(exp_lat));
    endtask

    task automatic pulse_resp(input int dly, input logic [127:0] rd);
        repeat (dly) @(negedge clk);
        l2_resp = 1'b1;
        l2_rdata = rd;
        @(negedge clk);
        l2_resp = 1'b0;
        l2_rdata = '0;
    endtask

    task automatic check_cnt(input logic [15:0] c0, c1, c2, c3);
        check("cnt0", 128'(ch_svc_count[15:0]), 128'(c0));
        check("cnt1", 128'(ch_svc_count[31:16]), 128'(c1));
        check("cnt2", 128'(ch_svc_count[47:32]), 128'(c2));
        check("cnt3", 128'(ch_svc_count[63:48]), 128'(c3));
    endtask

    initial begin
        logic [127:0] w1, w2;
        w1 = 128'h0123456789ABCDEF0123456789ABCDEF;
        w2 = 128'hCAFE0000111122223333444455556666;
        rst = 1'b1;
        ch_read = '0; ch_write = '0; l2_resp = 1'b0; l2_rdata = '0;
        ch_address = '0; ch_wdata = '0;
        // reset state
        repeat (2) @(negedge clk);
        check("rst_l2_read", 128'(l2_read), 128'd0);
        check("rst_l2_write", 128'(l2_write), 128'd0);
        check("rst_l2_addr", 128'(l2_address), 128'd0);
        check("rst_l2_wdata", l2_wdata, 128'd0);
        check("rst_ch_resp", 128'(ch_resp), 128'd0);
        check_cnt(0, 0, 0, 0);
        rst = 1'b0;
        // single read on ch0
        ch_address[15:0] = 16'h1000;
        ch_read[0] = 1'b1;
        push(0, 128'hDEAD0000111122223333444400BEEF, 16'h1000, 1'b0, '0);
        wait_strobe(1);
        pulse_resp(3, 128'hDEAD0000111122223333444400BEEF);
        ch_read[0] = 1'b0;
        @(negedge clk);
        check_cnt(1, 0, 0, 0);
        // ch0 and ch1 continuously requesting: 0,1,0,1
        do_reset();
        ch_address[15:0] = 16'h0A00;
        ch_address[31:16] = 16'h0B00;
        ch_read[1:0] = 2'b11;
        push(0, 128'h11, 16'h0A00, 1'b0, '0);
        push(1, 128'h22, 16'h0B00, 1'b0, '0);
        push(0, 128'h33, 16'h0A00, 1'b0, '0);
        push(1, 128'h44, 16'h0B00, 1'b0, '0);
        wait_strobe(1);
        pulse_resp(1, 128'h11);
        wait_strobe(2);
        pulse_resp(1, 128'h22);
        wait_strobe(2);
        pulse_resp(2, 128'h33);
        wait_strobe(2);
        pulse_resp(1, 128'h44);
        ch_read = '0;
        @(negedge clk);
        check_cnt(2, 2, 0, 0);
        // after serving ch1, ch1 and ch3 requesting: 3 then 1
        do_reset();
        ch_address[31:16] = 16'h0111;
        ch_address[63:48] = 16'h0333;
        ch_read[1] = 1'b1;
        push(1, 128'h55, 16'h0111, 1'b0, '0);
        wait_strobe(1);
        pulse_resp(1, 128'h55);
        ch_read[1] = 1'b0;
        @(negedge clk);
        ch_read[1] = 1'b1;
        ch_read[3] = 1'b1;
        push(3, 128'h66, 16'h0333, 1'b0, '0);
        push(1, 128'h77, 16'h0111, 1'b0, '0);
        wait_strobe(1);
        pulse_resp(1, 128'h66);
        ch_read[3] = 1'b0;
        wait_strobe(2);
        pulse_resp(1, 128'h77);
        ch_read[1] = 1'b0;
        @(negedge clk);
        check_cnt(0, 2, 0, 1);
        // write on ch1 with inputs changing mid-transaction
        ch_address[31:16] = 16'h2040;
        ch_wdata[255:128] = w1;
        ch_write[1] = 1'b1;
        push(1, 128'h88, 16'h2040, 1'b1, w1);
        wait_strobe(1);
        ch_address[31:16] = 16'hFFFF;
        ch_wdata[255:128] = ~w1;
        ch_write[1] = 1'b0;
        #1;
        check("busy_hold_addr", 128'(l2_address), 128'h2040);
        check("busy_hold_wdata", l2_wdata, w1);
        check("busy_hold_write", 128'(l2_write), 128'd1);
        pulse_resp(2, 128'h88);
        // read and write both high resolves as write
        ch_address[15:0] = 16'h3000;
        ch_wdata[127:0] = w2;
        ch_read[0] = 1'b1;
        ch_write[0] = 1'b1;
        push(0, 128'h99, 16'h3000, 1'b1, w2);
        wait_strobe(2);
        pulse_resp(1, 128'h99);
        ch_read[0] = 1'b0;
        ch_write[0] = 1'b0;
        @(negedge clk);
        check_cnt(1, 3, 0, 1);
        // reset mid-BUSY, l2_resp during and after reset is ignored
        ch_address[15:0] = 16'h4000;
        ch_address[31:16] = 16'h4100;
        ch_read[1] = 1'b1;
        wait_strobe(1);
        rst = 1'b1;
        l2_resp = 1'b1;
        l2_rdata = 128'hBAD;
        ch_read = '0;
        #1;
        check("rst_busy_no_resp", 128'(ch_resp), 128'd0);
        @(negedge clk);
        check("rst_strobe_read", 128'(l2_read), 128'd0);
        check("rst_strobe_write", 128'(l2_write), 128'd0);
        rst = 1'b0;
        #1;
        check("idle_resp_ignored", 128'(ch_resp), 128'd0);
        @(negedge clk);
        l2_resp = 1'b0;
        l2_rdata = '0;
        check_cnt(0, 0, 0, 0);
        ch_read[1:0] = 2'b11;
        push(0, 128'hAA, 16'h4000, 1'b0, '0);
        wait_strobe(1);
        pulse_resp(1, 128'hAA);
        ch_read = '0;
        @(negedge clk);
        check_cnt(1, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 128'(sbq.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
